// File: rtl/delta_sigma_dac.sv
// delta_sigma_dac
//   Second-order 1-bit delta-sigma DAC with a soft-mute gain ramp and a
//   sticky integrator-saturation flag.
//
// Parameters
//   ACC_W     signed width of both integrators (at least 17)
//   RAMP_DIV  clk cycles per one-LSB gain step while ramping
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   sample_in  signed 16-bit PCM sample (16x upsampled, held, no strobe)
//   mute       1 ramps the gain to silence, 0 ramps it to full scale
//   ovf_clr    single-cycle pulse clearing ovf
//   dac_out    registered 1-bit modulator output
//   muted      high while the mute FSM sits in MUTED
//   ovf        sticky flag, set whenever an integrator saturates
module delta_sigma_dac #(
  parameter int ACC_W    = 24,
  parameter int RAMP_DIV = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [15:0] sample_in,
  input  logic               mute,
  input  logic               ovf_clr,
  output logic               dac_out,
  output logic               muted,
  output logic               ovf
);

  localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);
  // Two guard bits: i2 + i1' - fb can reach about 2^ACC_W + 2^15.
  localparam int SUM_W = ACC_W + 2;
  localparam logic signed [ACC_W-1:0] I_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] I_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [8:0] GAIN_FULL = 9'd256;

  typedef enum logic [1:0] {
    S_MUTED,
    S_RAMP_UP,
    S_PLAY,
    S_RAMP_DOWN
  } state_e;

  state_e                    state_q, state_d;
  logic [8:0]                gain_q, gain_d;
  logic [DIV_W-1:0]          div_q, div_d;
  logic signed [15:0]        sample_q;
  logic signed [ACC_W-1:0]   i1_q, i1_d;
  logic signed [ACC_W-1:0]   i2_q, i2_d;
  logic                      dac_q, dac_d;
  logic                      ovf_q, ovf_d;

  logic signed [25:0]        prod;
  logic signed [15:0]        p;
  logic signed [16:0]        p_ext;
  logic signed [16:0]        x;
  logic signed [SUM_W-1:0]   fb;
  logic signed [SUM_W-1:0]   sum1, sum2;
  logic                      clip1, clip2;
  logic                      wrap;

  // Modulator datapath
  always_comb begin
    prod  = sample_q * $signed({1'b0, gain_q});
    p     = 16'(prod >>> 8);
    p_ext = 17'(p);
    x     = (p_ext >>> 1) + (p_ext >>> 2);
    fb    = dac_q ? SUM_W'(32768) : SUM_W'(-32768);

    sum1  = SUM_W'(i1_q) + SUM_W'(x) - fb;
    clip1 = 1'b0;
    if (sum1 > SUM_W'(I_MAX)) begin
      i1_d  = I_MAX;
      clip1 = 1'b1;
    end else if (sum1 < SUM_W'(I_MIN)) begin
      i1_d  = I_MIN;
      clip1 = 1'b1;
    end else begin
      i1_d  = ACC_W'(sum1);
    end

    sum2  = SUM_W'(i2_q) + SUM_W'(i1_d) - fb;
    clip2 = 1'b0;
    if (sum2 > SUM_W'(I_MAX)) begin
      i2_d  = I_MAX;
      clip2 = 1'b1;
    end else if (sum2 < SUM_W'(I_MIN)) begin
      i2_d  = I_MIN;
      clip2 = 1'b1;
    end else begin
      i2_d  = ACC_W'(sum2);
    end

    dac_d = ~i2_d[ACC_W-1];
    // A clamp in the same cycle as ovf_clr keeps the flag set.
    ovf_d = clip1 | clip2 | (ovf_q & ~ovf_clr);
  end

  // Mute FSM and gain ramp
  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    div_d   = div_q;
    wrap    = (div_q == DIV_LAST);

    unique case (state_q)
      S_MUTED: begin
        gain_d = '0;
        div_d  = '0;
        if (!mute) state_d = S_RAMP_UP;
      end

      S_RAMP_UP: begin
        if (mute) begin
          state_d = S_RAMP_DOWN;
          div_d   = '0;
        end else if (wrap) begin
          div_d = '0;
          // Saturating step: a reversal out of RAMP_DOWN can arrive at full gain.
          if (gain_q >= 9'd255) begin
            gain_d  = GAIN_FULL;
            state_d = S_PLAY;
          end else begin
            gain_d  = gain_q + 9'd1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      S_PLAY: begin
        gain_d = GAIN_FULL;
        div_d  = '0;
        if (mute) state_d = S_RAMP_DOWN;
      end

      S_RAMP_DOWN: begin
        if (!mute) begin
          state_d = S_RAMP_UP;
          div_d   = '0;
        end else if (wrap) begin
          div_d = '0;
          // Saturating step: a reversal out of RAMP_UP can arrive at zero gain.
          if (gain_q <= 9'd1) begin
            gain_d  = '0;
            state_d = S_MUTED;
          end else begin
            gain_d  = gain_q - 9'd1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      default: begin
        state_d = S_MUTED;
        gain_d  = '0;
        div_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_MUTED;
      gain_q   <= '0;
      div_q    <= '0;
      sample_q <= '0;
      i1_q     <= '0;
      i2_q     <= '0;
      dac_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gain_q   <= gain_d;
      div_q    <= div_d;
      sample_q <= sample_in;
      i1_q     <= i1_d;
      i2_q     <= i2_d;
      dac_q    <= dac_d;
      ovf_q    <= ovf_d;
    end
  end

  assign dac_out = dac_q;
  assign muted   = (state_q == S_MUTED);
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_delta_sigma_dac.sv
// tb_delta_sigma_dac
//   Two DUT copies (ACC_W=24 and ACC_W=18, both RAMP_DIV=4) share one
//   stimulus stream. A behavioural model predicts {dac_out, muted, ovf}
//   for every cycle; predictions are queued and a monitor compares them
//   one cycle at a time. Density windows, sticky/clear behaviour and an
//   asynchronous reset are checked directly.
module tb_delta_sigma_dac;

  localparam int RD     = 4;
  localparam int ACCW_A = 24;
  localparam int ACCW_B = 18;

  logic               clk;
  logic               rst_n;
  logic signed [15:0] sample_in;
  logic               mute;
  logic               ovf_clr;
  logic               dac_a, muted_a, ovf_a;
  logic               dac_b, muted_b, ovf_b;

  int checks   = 0;
  int failures = 0;
  bit done     = 0;

  logic [2:0] q0[$];
  logic [2:0] q1[$];

  // Behavioural model state, one slot per DUT copy
  longint m_i1[2];
  longint m_i2[2];
  bit     m_dac[2];
  bit     m_ovf[2];
  int     m_gain[2];
  int     m_cnt[2];
  int     m_sreg[2];
  string  m_st[2];

  delta_sigma_dac #(.ACC_W(ACCW_A), .RAMP_DIV(RD)) dut_a (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .mute(mute),
    .ovf_clr(ovf_clr), .dac_out(dac_a), .muted(muted_a), .ovf(ovf_a));

  delta_sigma_dac #(.ACC_W(ACCW_B), .RAMP_DIV(RD)) dut_b (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .mute(mute),
    .ovf_clr(ovf_clr), .dac_out(dac_b), .muted(muted_b), .ovf(ovf_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b required %b at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of the reference: takes the inputs presented now and
  // returns what the outputs must be just after the next rising edge.
  task automatic model_step(input int k, output logic [2:0] e);
    longint prod, p, x, fb, a, b, lim;
    bit clip;
    int accw;
    accw = (k == 0) ? ACCW_A : ACCW_B;
    if (!rst_n) begin
      m_i1[k] = 0; m_i2[k] = 0; m_dac[k] = 0; m_ovf[k] = 0;
      m_gain[k] = 0; m_cnt[k] = 0; m_sreg[k] = 0; m_st[k] = "MUTED";
      e = 3'b010;
      return;
    end
    prod = longint'(m_sreg[k]) * longint'(m_gain[k]);
    p    = prod >>> 8;
    x    = (p >>> 1) + (p >>> 2);
    fb   = m_dac[k] ? 64'sd32768 : -64'sd32768;
    lim  = longint'(1) << (accw - 1);
    clip = 0;
    a = m_i1[k] + x - fb;
    if (a > lim - 1) begin a = lim - 1; clip = 1; end
    else if (a < -lim) begin a = -lim; clip = 1; end
    b = m_i2[k] + a - fb;
    if (b > lim - 1) begin b = lim - 1; clip = 1; end
    else if (b < -lim) begin b = -lim; clip = 1; end
    m_i1[k]  = a;
    m_i2[k]  = b;
    m_dac[k] = (b >= 0);
    m_ovf[k] = clip || (m_ovf[k] && !ovf_clr);
    m_sreg[k] = int'(sample_in);

    if (m_st[k] == "MUTED") begin
      m_gain[k] = 0;
      m_cnt[k]  = 0;
      if (!mute) m_st[k] = "RAMP_UP";
    end else if (m_st[k] == "RAMP_UP") begin
      if (mute) begin
        m_st[k] = "RAMP_DOWN"; m_cnt[k] = 0;
      end else if (m_cnt[k] == RD - 1) begin
        m_cnt[k] = 0;
        m_gain[k] = (m_gain[k] + 1 > 256) ? 256 : m_gain[k] + 1;
        if (m_gain[k] == 256) m_st[k] = "PLAY";
      end else begin
        m_cnt[k]++;
      end
    end else if (m_st[k] == "PLAY") begin
      m_gain[k] = 256;
      m_cnt[k]  = 0;
      if (mute) m_st[k] = "RAMP_DOWN";
    end else begin
      if (!mute) begin
        m_st[k] = "RAMP_UP"; m_cnt[k] = 0;
      end else if (m_cnt[k] == RD - 1) begin
        m_cnt[k] = 0;
        m_gain[k] = (m_gain[k] - 1 < 0) ? 0 : m_gain[k] - 1;
        if (m_gain[k] == 0) m_st[k] = "MUTED";
      end else begin
        m_cnt[k]++;
      end
    end
    e = {m_dac[k], (m_st[k] == "MUTED"), m_ovf[k]};
  endtask

  // Push predictions for the coming edge, then move to the next falling edge.
  task automatic tick();
    logic [2:0] e;
    model_step(0, e);
    q0.push_back(e);
    model_step(1, e);
    q1.push_back(e);
    @(negedge clk);
  endtask

  // Random samples until the model reaches a state (gain_tgt < 0) or a gain.
  task automatic run_until(input string st, input int gain_tgt, input int maxc,
                           input string name);
    int n = 0;
    while (!((gain_tgt < 0) ? (m_st[0] == st) : (m_gain[0] == gain_tgt))) begin
      if (n >= maxc) begin
        checks++; failures++;
        $display("FAIL %s: wait expired after %0d cycles, got state %s gain %0d", name, n,
                 m_st[0], m_gain[0]);
        return;
      end
      sample_in = 16'($urandom);
      tick();
      n++;
    end
  endtask

  task automatic window(input logic signed [15:0] s, input int lo, input int hi,
                        input string name, input bit pulse_clr, output bit seen_b);
    int ones = 0;
    bit seen_a = 0;
    seen_b = 0;
    sample_in = s;
    repeat (64) tick();
    for (int i = 0; i < 4096; i++) begin
      ovf_clr = pulse_clr && (i % 16 == 0) && (i < 4000);
      tick();
      ones += int'(dac_a);
      if (ovf_a) seen_a = 1;
      if (ovf_b) seen_b = 1;
    end
    ovf_clr = 0;
    checks++;
    if (ones < lo || ones > hi) begin
      failures++;
      $display("FAIL %s: ones count %0d required %0d..%0d", name, ones, lo, hi);
    end
    check1({name, "_ovf_a"}, seen_a, 1'b0);
  endtask

  // Scoreboard monitor
  initial begin
    logic [2:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (done) continue;
      checks++;
      if (q0.size() == 0) begin
        failures++;
        $display("FAIL sb_a: no prediction queued at %0t", $time);
      end else begin
        e = q0.pop_front();
        if ({dac_a, muted_a, ovf_a} !== e) begin
          failures++;
          $display("FAIL sb_a: {dac,muted,ovf} got %b required %b at %0t",
                   {dac_a, muted_a, ovf_a}, e, $time);
        end
      end
      checks++;
      if (q1.size() == 0) begin
        failures++;
        $display("FAIL sb_b: no prediction queued at %0t", $time);
      end else begin
        e = q1.pop_front();
        if ({dac_b, muted_b, ovf_b} !== e) begin
          failures++;
          $display("FAIL sb_b: {dac,muted,ovf} got %b required %b at %0t",
                   {dac_b, muted_b, ovf_b}, e, $time);
        end
      end
    end
  end

  // Stimulus
  initial begin
    bit seen_b;
    rst_n = 1'b0; mute = 1'b0; ovf_clr = 1'b0; sample_in = '0;
    repeat (3) tick();
    rst_n = 1'b1;

    // unmute: muted drops after one edge, then ramp to PLAY
    sample_in = 16'($urandom);
    tick();
    check1("muted_drop_a", muted_a, 1'b0);
    check1("muted_drop_b", muted_b, 1'b0);
    run_until("PLAY", -1, 256 * RD + 16, "ramp_to_play");
    check1("play_not_muted", muted_a, 1'b0);

    // density windows in PLAY; clr pulses while the 18-bit copy clamps
    window(16'sh7FFF, 3576, 3592, "ones_pos_fs", 1'b1, seen_b);
    check1("ovf_b_set_fs", seen_b, 1'b1);
    window(16'sh8000, 504, 520, "ones_neg_fs", 1'b0, seen_b);
    window(16'sh0000, 2044, 2052, "ones_zero", 1'b0, seen_b);
    check1("ovf_b_sticky", ovf_b, 1'b1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    tick();
    check1("ovf_b_cleared", ovf_b, 1'b0);

    // ramp reversals part-way through
    mute = 1'b1;
    run_until("MUTED", -1, 256 * RD + 16, "ramp_to_muted");
    check1("muted_high", muted_a, 1'b1);
    mute = 1'b0;
    run_until("", 100, 110 * RD, "up_to_100");
    mute = 1'b1;
    run_until("", 90, 12 * RD, "down_to_90");
    check1("reverse_not_muted", muted_a, 1'b0);
    mute = 1'b0;
    run_until("PLAY", -1, 256 * RD + 16, "back_to_play");

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) mute = ~mute;
      ovf_clr = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 3) == 0) sample_in = ($urandom_range(0, 1) == 0) ? 16'sh7FFF : 16'sh8000;
      else sample_in = 16'($urandom);
      tick();
    end
    ovf_clr = 1'b0;

    // asynchronous reset in PLAY, observed before the next clock edge
    mute = 1'b0;
    run_until("PLAY", -1, 2 * 256 * RD + 16, "replay");
    sample_in = 16'sh7FFF;
    repeat (40) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check1("arst_dac_a", dac_a, 1'b0);
    check1("arst_muted_a", muted_a, 1'b1);
    check1("arst_ovf_a", ovf_a, 1'b0);
    check1("arst_dac_b", dac_b, 1'b0);
    check1("arst_muted_b", muted_b, 1'b1);
    check1("arst_ovf_b", ovf_b, 1'b0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (40) begin
      sample_in = 16'($urandom);
      tick();
    end

    done = 1'b1;
    repeat (2) @(posedge clk);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: %0d/%0d predictions left, required 0/0", q0.size(), q1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/delta_sigma_dac.md
DELTA_SIGMA_DAC -- requirements
Module: delta_sigma_dac

Interface
REQ-001 The block SHALL provide parameter ACC_W, default 24: signed width of both integrators.
REQ-002 The block SHALL provide parameter RAMP_DIV, default 256: clk cycles per one-LSB soft-mute gain step.
REQ-003 clk  input  1  system clock; all state SHALL change only on its rising edge, except on reset.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 sample_in  input  16  signed held PCM sample, 16x-upsampled; may change on any cycle, no valid strobe.
REQ-006 mute  input  1  level; 1 requests ramp to silence, 0 requests ramp to full gain.
REQ-007 ovf_clr  input  1  single-cycle pulse clearing ovf.
REQ-008 dac_out  output  1  registered 1-bit modulator output to the analog reconstruction filter.
REQ-009 muted  output  1  high while the state is MUTED.
REQ-010 ovf  output  1  sticky flag: an integrator saturated.

Function
REQ-011 sample_in SHALL be registered into sample_reg every cycle.
REQ-012 The scaled product p SHALL be (sample_reg * gain) >>> 8, with gain unsigned 9-bit in 0..256; p is 16-bit signed.
REQ-013 The modulator input x SHALL be (p >>> 1) + (p >>> 2), i.e. 3/4 scaling for loop stability; x lies in -24576..24575.
REQ-014 Feedback fb SHALL be +32768 when dac_out=1 and -32768 when dac_out=0.
REQ-015 Each cycle the block SHALL compute i1' = sat(i1 + x - fb) and i2' = sat(i2 + i1' - fb), then register i1', i2', and dac_out' = (i2' >= 0).
REQ-016 sat() SHALL clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1] using full-precision intermediate sums with no wrap-around.
REQ-017 Latency from a sample_in change to the first affected dac_out SHALL be 2 cycles.
REQ-018 ovf SHALL be set in any cycle where either sat() clamps, and cleared by ovf_clr; if both occur in the same cycle, set SHALL win.
REQ-019 The mute FSM SHALL have states MUTED, RAMP_UP, PLAY and RAMP_DOWN, and a divider counter counting 0..RAMP_DIV-1.
REQ-020 MUTED with mute=0 SHALL go to RAMP_UP; MUTED with mute=1 SHALL stay MUTED with gain=0.
REQ-021 In RAMP_UP, gain SHALL increment by 1 when the divider wraps; on reaching 256 the FSM SHALL go to PLAY.
REQ-022 In RAMP_UP, mute=1 SHALL move the FSM to RAMP_DOWN next cycle, starting from the current gain.
REQ-023 PLAY with mute=1 SHALL go to RAMP_DOWN; gain SHALL hold at 256 in PLAY.
REQ-024 In RAMP_DOWN, gain SHALL decrement by 1 on each divider wrap; on reaching 0 the FSM SHALL go to MUTED.
REQ-025 In RAMP_DOWN, mute=0 SHALL move the FSM to RAMP_UP from the current gain.
REQ-026 The divider SHALL clear to 0 on every FSM state change.
REQ-027 gain SHALL never leave 0..256.
REQ-028 The modulator SHALL run continuously in all states; with gain=0 it idles at about 50% density, with no pop on unmute.

Reset
REQ-029 While rst_n=0, the block SHALL hold sample_reg=0, i1=0, i2=0, dac_out=0, ovf=0, gain=0, divider=0, state=MUTED, muted=1.
REQ-030 Reset asserted mid-ramp or mid-overflow SHALL take effect immediately, without waiting for clk.
REQ-031 After rst_n deasserts, the first state update SHALL occur on the following rising clk edge.

Verification
REQ-032 Reset, mute=0, sample_in=0 -> muted drops after 1 cycle; gain reaches 256 after 256*RAMP_DIV cycles, then state=PLAY.
REQ-033 PLAY, sample_in=16'h7FFF, 4096-cycle window -> dac_out ones count 3584 +/-8, ovf stays 0.
REQ-034 PLAY, sample_in=16'h8000, 4096-cycle window -> ones count 512 +/-8; sample_in=0 -> 2048 +/-4.
REQ-035 RAMP_DIV=4, mute toggles 1 at gain=100 then 0 at gain=90 -> FSM goes RAMP_DOWN then RAMP_UP, gain continuous, divider cleared at each change.
REQ-036 ACC_W=18 with full-scale input -> ovf sets and i1/i2 clamp at +/-131071/-131072; a simultaneous ovf_clr does not clear ovf; a later ovf_clr with no clamp clears it.
REQ-037 rst_n pulsed low asynchronously in PLAY -> all REQ-029 values are seen before the next clk edge.
